// File: rtl/adrv9001_spi_responder.sv
// ---------------------------------------------------------------------------
// adrv9001_spi_responder
//
// SPI mode-0 responder that turns 24-bit frames from an external SPI
// initiator into register-bus strobes in the clk domain. Frame layout:
// bit 23 = R/W (1 = read), bits 22:8 = register address, bits 7:0 = data.
// The SPI pins are oversampled: clk must run at least 8x spi_clk.
//
// Ports:
//   clk, rstn              system clock, async active-low reset
//   spi_clk/csn/mosi       SPI inputs (asynchronous to clk)
//   spi_miso, spi_miso_t   read data out and its tristate (1 = high-Z)
//   reg_addr               address of the current transaction
//   reg_wr_en/reg_wr_data  one-cycle write strobe with its data
//   reg_rd_en/reg_rd_data  one-cycle read request; data sampled 1 clk later
//   busy                   frame in progress
//   frame_err              one-cycle pulse when csn rises mid-frame
// ---------------------------------------------------------------------------
module adrv9001_spi_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter logic MISO_IDLE   = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_clk,
  input  logic        spi_csn,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_t,
  output logic [14:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  // Arming needs this many consecutive high csn samples after reset, which
  // is longer than the reset value of the csn chain can fake.
  localparam logic [3:0] ARM_LAST = 4'(2 * SYNC_STAGES - 1);

  // ---------------- input synchronizers and edge detection ----------------
  logic [SYNC_STAGES-1:0] sclk_sync_reg, csn_sync_reg, mosi_sync_reg;
  logic                   sclk_d_reg, csn_d_reg;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_reg <= '0;
      csn_sync_reg  <= '1;
      mosi_sync_reg <= '0;
      sclk_d_reg    <= 1'b0;
      csn_d_reg     <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
      csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], spi_csn};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      sclk_d_reg    <= sclk_s;
      csn_d_reg     <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign csn_s     = csn_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign csn_rise  = csn_s & ~csn_d_reg;
  assign csn_fall  = ~csn_s & csn_d_reg;

  // ---------------- frame engine ----------------
  state_t      state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] shift_reg, shift_next, shift_in;
  logic [14:0] addr_reg, addr_next;
  logic [7:0]  wr_data_reg, wr_data_next;
  logic [7:0]  out_shift_reg, out_shift_next;
  logic        wr_pend_reg, wr_pend_next;
  logic        wr_en_reg, wr_en_next;
  logic        rd_en_reg, rd_en_next;
  logic        rd_pend_reg, rd_pend_next;
  logic        miso_reg, miso_next;
  logic        frame_err_reg, frame_err_next;
  logic [3:0]  arm_cnt_reg, arm_cnt_next;
  logic        armed_reg, armed_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      out_shift_reg <= '0;
      wr_pend_reg   <= 1'b0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      rd_pend_reg   <= 1'b0;
      miso_reg      <= MISO_IDLE;
      frame_err_reg <= 1'b0;
      arm_cnt_reg   <= '0;
      armed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      addr_reg      <= addr_next;
      wr_data_reg   <= wr_data_next;
      out_shift_reg <= out_shift_next;
      wr_pend_reg   <= wr_pend_next;
      wr_en_reg     <= wr_en_next;
      rd_en_reg     <= rd_en_next;
      rd_pend_reg   <= rd_pend_next;
      miso_reg      <= miso_next;
      frame_err_reg <= frame_err_next;
      arm_cnt_reg   <= arm_cnt_next;
      armed_reg     <= armed_next;
    end
  end

  assign shift_in = {shift_reg[14:0], mosi_s};

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    addr_next      = addr_reg;
    wr_data_next   = wr_data_reg;
    out_shift_next = out_shift_reg;
    wr_pend_next   = 1'b0;
    wr_en_next     = wr_pend_reg;   // write strobe trails the data load by one cycle
    rd_en_next     = 1'b0;
    rd_pend_next   = rd_en_reg;     // read data is valid the cycle after rd_en
    miso_next      = miso_reg;
    frame_err_next = 1'b0;

    // A csn already low when reset releases must not look like a fresh
    // falling edge, so frames are accepted only once csn was seen high.
    arm_cnt_next = !csn_s ? 4'd0 : ((arm_cnt_reg == ARM_LAST) ? arm_cnt_reg : 4'(arm_cnt_reg + 4'd1));
    armed_next   = armed_reg | (csn_s && (arm_cnt_reg == ARM_LAST));

    if (rd_pend_reg) out_shift_next = reg_rd_data;

    unique case (state_reg)
      IDLE: begin
        if (csn_fall && armed_reg) begin
          state_next   = CMD;
          bit_cnt_next = '0;
          miso_next    = MISO_IDLE;
        end
      end
      CMD, WDATA, RDATA: begin
        // csn rising beats any spi_clk edge seen in the same cycle
        if (csn_rise) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
        end else begin
          if ((state_reg == RDATA) && sclk_fall) begin
            miso_next      = out_shift_reg[7];
            out_shift_next = {out_shift_reg[6:0], 1'b0};
          end
          if (sclk_rise) begin
            shift_next   = shift_in;
            bit_cnt_next = 5'(bit_cnt_reg + 5'd1);
            if ((state_reg == CMD) && (bit_cnt_reg == 5'd15)) begin
              addr_next = shift_in[14:0];
              if (shift_in[15]) begin
                state_next = RDATA;
                rd_en_next = 1'b1;
              end else begin
                state_next = WDATA;
              end
            end
            if (bit_cnt_reg == 5'd23) begin
              if (state_reg == WDATA) begin
                wr_data_next = shift_in[7:0];
                wr_pend_next = 1'b1;
              end
              state_next = DONE;
            end
          end
        end
      end
      DONE: begin
        if (csn_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign spi_miso    = (state_reg == RDATA) ? miso_reg : MISO_IDLE;
  assign spi_miso_t  = (state_reg != RDATA);
  assign reg_addr    = addr_reg;
  assign reg_wr_en   = wr_en_reg;
  assign reg_wr_data = wr_data_reg;
  assign reg_rd_en   = rd_en_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_adrv9001_spi_responder.sv
module tb_adrv9001_spi_responder;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_t;
  logic [14:0] reg_addr;
  logic        reg_wr_en, reg_rd_en, busy, frame_err;
  logic [7:0]  reg_wr_data;
  logic [7:0]  reg_rd_data = 8'h00;

  adrv9001_spi_responder #(.SYNC_STAGES(SYNC), .MISO_IDLE(1'b0)) dut (
    .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_t(spi_miso_t), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // register-file model: returns mem[addr] the cycle after a read request
  logic [7:0] mem [0:32767];
  always @(posedge clk) if (reg_rd_en) reg_rd_data <= mem[reg_addr];

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0;
  logic [23:0] sb_q[$];

  // strobe monitor: every strobe pops the scoreboard
  always @(negedge clk) begin
    logic [23:0] exp_e;
    if (rstn) begin
      if (reg_wr_en && reg_rd_en) begin
        tests_run++; tests_failed++;
        $display("FAIL strobe_overlap: wr_en and rd_en both high, required exclusive");
      end
      if (reg_wr_en) begin
        wr_cnt++; tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_wr: addr=%h data=%h, required no strobe", reg_addr, reg_wr_data);
        end else begin
          exp_e = sb_q.pop_front();
          $display("[TB] wr addr=%h data=%h", reg_addr, reg_wr_data);
          if ({1'b0, reg_addr, reg_wr_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL wr_strobe: got %h required %h", {1'b0, reg_addr, reg_wr_data}, exp_e);
          end
        end
      end
      if (reg_rd_en) begin
        rd_cnt++; tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_rd: addr=%h, required no strobe", reg_addr);
        end else begin
          exp_e = sb_q.pop_front();
          $display("[TB] rd addr=%h", reg_addr);
          if ({1'b1, reg_addr} !== exp_e[23:8]) begin
            tests_failed++;
            $display("FAIL rd_strobe: got %h required %h", {1'b1, reg_addr}, exp_e[23:8]);
          end
        end
      end
      if (frame_err) ferr_cnt++;
    end
  end

  // Drives nbits of a frame MSB first; samples MISO on read data bits and
  // counts spi_miso_t deviations at every rising spi_clk.
  task automatic spi_xfer(input logic [23:0] frame, input int nbits, input bit raise_csn,
                          output logic [7:0] miso_byte, output int t_err);
    logic exp_t;
    miso_byte = 8'h00;
    t_err = 0;
    @(negedge clk);
    spi_csn = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 24) ? frame[23 - i] : 1'b0;
      #40 spi_clk = 1'b1;
      exp_t = (frame[23] && i >= 16 && i < 24) ? 1'b0 : 1'b1;
      if (spi_miso_t !== exp_t) t_err++;
      if (i >= 16 && i < 24) miso_byte = {miso_byte[6:0], spi_miso};
      #40 spi_clk = 1'b0;
    end
    if (raise_csn) begin
      #80 spi_csn = 1'b1;
      #80;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests_run++;
    if (got !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic check_reset_values(input string name);
    chk(name, {busy, spi_miso_t, spi_miso, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, frame_err},
        {1'b0, 1'b1, 1'b0, 15'h0, 1'b0, 8'h0, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_reset", {busy, spi_miso_t}, 2'b01);
  endtask

  task automatic test_write();
    logic [7:0] mb; int te; int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    sb_q.push_back(24'h012A5C);
    spi_xfer(24'h012A5C, 24, 1, mb, te);
    chk("write_count", wr_cnt - w0, 1);
    chk("write_ferr", ferr_cnt - f0, 0);
    chk("write_miso_t", te, 0);
    chk("write_sb_empty", sb_q.size(), 0);
    chk("write_idle", busy, 0);
  endtask

  task automatic test_read();
    logic [7:0] mb; int te; int r0, f0;
    r0 = rd_cnt; f0 = ferr_cnt;
    mem[15'h003F] = 8'hA7;
    sb_q.push_back(24'h803F00);
    spi_xfer(24'h803F6B, 24, 1, mb, te);
    $display("[TB] read miso byte=%h", mb);
    chk("read_miso", mb, 8'hA7);
    chk("read_count", rd_cnt - r0, 1);
    chk("read_miso_t", te, 0);
    chk("read_ferr", ferr_cnt - f0, 0);
    chk("read_tristate_after", spi_miso_t, 1);
  endtask

  task automatic test_abort();
    logic [7:0] mb; int te; int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_xfer(24'h0ABCDE, 20, 0, mb, te);
    @(negedge clk);
    spi_csn = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    chk("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("abort_ferr", ferr_cnt - f0, 1);
    chk("abort_no_wr", wr_cnt - w0, 0);
  endtask

  task automatic test_simultaneous();
    logic [7:0] mb; int te; int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_xfer(24'h004411, 23, 0, mb, te);
    spi_mosi = 1'b1;
    #40;
    spi_clk = 1'b1;
    spi_csn = 1'b1;
    #40 spi_clk = 1'b0;
    #120;
    chk("simul_ferr", ferr_cnt - f0, 1);
    chk("simul_no_wr", wr_cnt - w0, 0);
  endtask

  task automatic test_overlong();
    logic [7:0] mb; int te; int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    sb_q.push_back(24'h000155);
    spi_xfer(24'h000155, 32, 1, mb, te);
    chk("overlong_wr", wr_cnt - w0, 1);
    chk("overlong_ferr", ferr_cnt - f0, 0);
    chk("overlong_sb_empty", sb_q.size(), 0);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] mb; int te; int w0;
    sb_q.push_back(24'h812300);
    spi_xfer(24'h812300, 18, 0, mb, te);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_values("mid_read_reset_values");
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("csn_low_no_start", busy, 0);
    spi_csn = 1'b1;
    repeat (20) @(negedge clk);
    w0 = wr_cnt;
    sb_q.push_back(24'h000201);
    spi_xfer(24'h000201, 24, 1, mb, te);
    chk("post_reset_wr", wr_cnt - w0, 1);
    chk("post_reset_sb_empty", sb_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] mb; int te; int s0, f0, terr;
    logic [14:0] a; logic [7:0] d; bit rw;
    s0 = wr_cnt + rd_cnt; f0 = ferr_cnt; terr = 0;
    for (int n = 0; n < 100; n++) begin
      rw = 1'($urandom_range(0, 1));
      a = 15'($urandom);
      d = 8'($urandom);
      sb_q.push_back(rw ? {1'b1, a, 8'h00} : {1'b0, a, d});
      spi_xfer({rw, a, d}, 24, 1, mb, te);
      terr += te;
      if (rw) chk("b2b_read_data", mb, mem[a]);
    end
    chk("b2b_strobes", (wr_cnt + rd_cnt) - s0, 100);
    chk("b2b_ferr", ferr_cnt - f0, 0);
    chk("b2b_miso_t", terr, 0);
    chk("b2b_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_simultaneous();
    test_overlong();
    test_reset_mid_read();
    test_back_to_back();
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/adrv9001_spi_responder.md
ADRV9001_SPI_RESPONDER -- requirements
Module: adrv9001_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for spi_clk/spi_csn/spi_mosi (legal 2..4).
REQ-002 SHALL have parameter MISO_IDLE, default 1'b0, meaning spi_miso value driven when not shifting read data.
REQ-003 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port spi_clk, input, 1, meaning SPI serial clock from initiator, asynchronous to clk.
REQ-006 SHALL have port spi_csn, input, 1, meaning chip select, active-low.
REQ-007 SHALL have port spi_mosi, input, 1, meaning serial data from initiator.
REQ-008 SHALL have port spi_miso, output, 1, meaning serial data to initiator.
REQ-009 SHALL have port spi_miso_t, output, 1, meaning MISO tristate control (1 = high-Z).
REQ-010 SHALL have port reg_addr, output, 15, meaning register address of current transaction.
REQ-011 SHALL have port reg_wr_en, output, 1, meaning one-cycle write strobe.
REQ-012 SHALL have port reg_wr_data, output, 8, meaning write data, valid with reg_wr_en.
REQ-013 SHALL have port reg_rd_en, output, 1, meaning one-cycle read request.
REQ-014 SHALL have port reg_rd_data, input, 8, meaning read data, sampled exactly 1 clk after reg_rd_en.
REQ-015 SHALL have port busy, output, 1, meaning transaction in progress (state != IDLE).
REQ-016 SHALL have port frame_err, output, 1, meaning one-cycle pulse on malformed frame.

Function
REQ-017 SHALL synchronize spi_clk, spi_csn, spi_mosi through SYNC_STAGES flops; edges detected on synchronized copies; clk SHALL be >= 8x spi_clk (system constraint).
REQ-018 SHALL implement SPI mode 0: sample MOSI on rising spi_clk, update MISO on falling spi_clk, MSB first.
REQ-019 SHALL decode a 24-bit frame: bit 23 = R/W (1 read, 0 write), bits 22:8 = address, bits 7:0 = data.
REQ-020 SHALL implement states IDLE, CMD, WDATA, RDATA, DONE.
REQ-021 IDLE -> CMD on synchronized csn falling edge; bit counter cleared to 0.
REQ-022 CMD: shift 16 bits; on 16th rising edge load reg_addr, go to RDATA if R/W=1 else WDATA.
REQ-023 On CMD->RDATA, reg_rd_en SHALL pulse in the same cycle as the transition; reg_rd_data captured next cycle into the shift-out register.
REQ-024 RDATA: spi_miso_t = 0; spi_miso SHALL present bit 7 after the 16th falling edge, then bits 6..0 on subsequent falling edges; -> DONE after 24th rising edge.
REQ-025 WDATA: shift 8 bits; on 24th rising edge reg_wr_data loaded and reg_wr_en pulsed one cycle later (single pulse); -> DONE.
REQ-026 DONE: further spi_clk edges ignored, no strobes; -> IDLE on csn rising edge.
REQ-027 csn rising edge in CMD, WDATA or RDATA: -> IDLE, no reg_wr_en, frame_err pulse 1 cycle; a reg_rd_en already issued stands.
REQ-028 csn rising edge in DONE: no frame_err.
REQ-029 Outside RDATA: spi_miso_t = 1, spi_miso = MISO_IDLE.
REQ-030 spi_clk edges while csn high SHALL be ignored.
REQ-031 Simultaneous csn rise and spi_clk rise in same cycle: csn wins; bit discarded.
REQ-032 reg_wr_en and reg_rd_en SHALL never assert in the same cycle nor more than once per frame.

Reset
REQ-033 On rstn low: state IDLE, synchronizers to idle (spi_csn chain = 1, others = 0), spi_miso = MISO_IDLE, spi_miso_t = 1, reg_addr = 0, reg_wr_data = 0, reg_wr_en = 0, reg_rd_en = 0, busy = 0, frame_err = 0.
REQ-034 rstn asserted mid-frame SHALL abort without strobes; after release, block waits for a new csn falling edge (a csn already low SHALL NOT start a frame).

Verification
REQ-035 Write: frame 0x012A5C (W, addr 0x012A, data 0x5C) -> one reg_wr_en, reg_addr = 0x012A, reg_wr_data = 0x5C, frame_err = 0.
REQ-036 Read: frame 0x80_3F_xx (addr 0x003F), reg_rd_data = 0xA7 -> one reg_rd_en, MISO bits 16..23 = 1,0,1,0,0,1,1,1, spi_miso_t low only during RDATA.
REQ-037 Abort: csn high after 20 bits of a write -> no reg_wr_en, frame_err pulse, busy = 0 within SYNC_STAGES+2 cycles.
REQ-038 Overlong: 32 clocks on write 0x000155 -> exactly one reg_wr_en with data 0x55, no frame_err.
REQ-039 Reset mid-read after 18 bits -> all outputs at reset values; next full write frame 0x000201 completes normally.
REQ-040 Ratio stress: clk = 8x spi_clk, 100 random back-to-back read/write frames -> scoreboard matches every address/data, zero frame_err.
